// File: rtl/dma_stream_stim_gen.sv
// Numbered-beat traffic source for the C2H DMA path with fixed, ramp or LFSR inter-beat gaps.
// Gap cycles only elapse while the sink is ready, so backpressure stretches gaps and holds beats.
module dma_stream_stim_gen #(
  parameter int DATA_W = 512,
  parameter int CNT_W  = 32,
  parameter int GAP_W  = 5
) (
  input  logic              clk,
  input  logic              rst_en,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [GAP_W-1:0]  gap_cfg,
  input  logic [15:0]       seed,
  input  logic [CNT_W-1:0]  beat_total,
  input  logic              data_next,
  output logic              io_enable,
  output logic [DATA_W-1:0] io_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  beat_cnt
);

  typedef enum logic [1:0] {IDLE, GAP, EMIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] seq;
  logic [GAP_W-1:0] k;
  logic [GAP_W-1:0] gap_left;
  logic [15:0]      lfsr;
  logic             stop_pending;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [GAP_W-1:0] gap_of(input logic [1:0] m, input logic [GAP_W-1:0] cfg,
                                               input logic [GAP_W-1:0] kk, input logic [15:0] l);
    case (m)
      2'd1:    return cfg + kk;
      2'd2:    return l[GAP_W-1:0];
      default: return cfg;
    endcase
  endfunction

  logic [15:0]       seed_fix;
  logic [15:0]       lfsr_adv;
  logic [GAP_W-1:0]  k_inc;
  logic [GAP_W-1:0]  gap_start;
  logic [GAP_W-1:0]  gap_after;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_beat;
  logic [CNT_W-1:0]  pat_src;
  logic [DATA_W-1:0] pattern;

  assign seed_fix  = (seed == 16'd0) ? 16'd1 : seed;
  assign lfsr_adv  = lfsr_step(lfsr);
  assign k_inc     = k + 1'b1;
  assign gap_start = gap_of(mode, gap_cfg, '0, seed_fix);
  assign gap_after = gap_of(mode, gap_cfg, k_inc, lfsr_adv);
  assign cnt_inc   = beat_cnt + 1'b1;
  assign last_beat = ((beat_total != '0) && (cnt_inc == beat_total)) || stop_pending || stop;

  // In EMIT the payload being loaded belongs to the beat after the one being accepted.
  assign pat_src = (state == EMIT) ? seq + 1'b1 : seq;

  localparam int NCH = (DATA_W + CNT_W - 1) / CNT_W;
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
    localparam int LO = gi * CNT_W;
    localparam int W  = (DATA_W - LO < CNT_W) ? (DATA_W - LO) : CNT_W;
    assign pattern[LO +: W] = pat_src[W-1:0];
  end

  always_ff @(posedge clk or posedge rst_en) begin
    if (rst_en) begin
      state        <= IDLE;
      seq          <= '0;
      k            <= '0;
      gap_left     <= '0;
      lfsr         <= 16'd1;
      stop_pending <= 1'b0;
      io_enable    <= 1'b0;
      io_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      beat_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!stop && start) begin
            beat_cnt <= '0;
            seq      <= {{(CNT_W-1){1'b0}}, 1'b1};
            k        <= '0;
            lfsr     <= seed_fix;
            gap_left <= gap_start;
            busy     <= 1'b1;
            state    <= GAP;
          end
        end
        GAP: begin
          if (stop) begin
            busy         <= 1'b0;
            done         <= 1'b1;
            stop_pending <= 1'b0;
            state        <= IDLE;
          end else if (data_next) begin
            if (gap_left != '0) begin
              gap_left <= gap_left - 1'b1;
            end else begin
              io_enable <= 1'b1;
              io_data   <= pattern;
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (data_next) begin
            beat_cnt <= cnt_inc;
            seq      <= seq + 1'b1;
            k        <= k_inc;
            lfsr     <= lfsr_adv;
            if (last_beat) begin
              io_enable    <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              stop_pending <= 1'b0;
              state        <= IDLE;
            end else if (gap_after == '0) begin
              io_data <= pattern;
            end else begin
              // The accepting edge itself counts as the first idle cycle.
              io_enable <= 1'b0;
              gap_left  <= gap_after - 1'b1;
              state     <= GAP;
            end
          end else if (stop) begin
            stop_pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_stream_stim_gen.sv
// Directed bench for dma_stream_stim_gen: expected beats are queued at run start and
// popped as the DUT offers them; timing is checked in sink-ready cycles since start.
module tb_dma_stream_stim_gen;

  localparam int DATA_W = 80;
  localparam int CNT_W  = 32;
  localparam int GAP_W  = 5;

  logic              clk = 1'b0;
  logic              rst_en;
  logic              start, stop, data_next;
  logic [1:0]        mode;
  logic [GAP_W-1:0]  gap_cfg;
  logic [15:0]       seed;
  logic [CNT_W-1:0]  beat_total;
  logic              io_enable, busy, done;
  logic [DATA_W-1:0] io_data;
  logic [CNT_W-1:0]  beat_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          v;
    logic [31:0] seq;
  } exp_t;
  exp_t q[$];

  dma_stream_stim_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst_en(rst_en), .start(start), .stop(stop), .mode(mode),
    .gap_cfg(gap_cfg), .seed(seed), .beat_total(beat_total), .data_next(data_next),
    .io_enable(io_enable), .io_data(io_data), .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] v);
    logic [15:0] n;
    n = {1'b0, v[15:1]};
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic int gap_m(input logic [1:0] m, input logic [4:0] gc, input int j, input logic [15:0] l);
    logic [4:0] s;
    s = gc + j[4:0];
    if (m == 2'd1) return int'(s);
    if (m == 2'd2) return int'(l[4:0]);
    return int'(gc);
  endfunction

  function automatic logic [DATA_W-1:0] pat_m(input logic [31:0] s);
    logic [DATA_W-1:0] p;
    for (int i = 0; i < DATA_W; i++) p[i] = s[i % CNT_W];
    return p;
  endfunction

  // Runs one stream. Sink drops ready during iterations [b1s,b1s+b1l) and [b2s,b2s+b2l).
  // stop_after >= 0: pulse stop during the first gap after that many accepted beats.
  task automatic run_stream(input string tag, input logic [1:0] m, input logic [4:0] gc,
                            input logic [15:0] sd, input logic [31:0] total, input int nbeats,
                            input int stop_after, input int b1s, input int b1l,
                            input int b2s, input int b2l);
    logic [15:0] l;
    int v, r, acc, it;
    bit dn, stop_now, ended;
    exp_t e;
    l = (sd == 16'd0) ? 16'd1 : sd;
    v = 0;
    for (int j = 0; j < nbeats; j++) begin
      v += 1 + gap_m(m, gc, j, l);
      q.push_back('{v, 32'(j + 1)});
      l = m_step(l);
    end
    @(negedge clk);
    mode = m; gap_cfg = gc; seed = sd; beat_total = total; start = 1'b1; data_next = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_start"}, DATA_W'(busy), DATA_W'(1));
    r = 0; acc = 0; it = 0; ended = 0;
    while (!ended) begin
      dn = !((it >= b1s && it < b1s + b1l) || (it >= b2s && it < b2s + b2l));
      stop_now = (stop_after >= 0) && (acc == stop_after) && !io_enable;
      if (stop_now) dn = 1'b1;
      if (io_enable) begin
        if (q.size() == 0) begin
          chk({tag, "_extra_beat"}, DATA_W'(1), DATA_W'(0));
          ended = 1;
        end else if (dn) begin
          e = q.pop_front();
          chk($sformatf("%s_data%0d", tag, acc), io_data, pat_m(e.seq));
          chk($sformatf("%s_time%0d", tag, acc), DATA_W'(r), DATA_W'(e.v));
          chk($sformatf("%s_cnt%0d", tag, acc), DATA_W'(beat_cnt), DATA_W'(acc));
          acc++;
        end else begin
          chk({tag, "_hold_data"}, io_data, pat_m(q[0].seq));
          chk({tag, "_hold_cnt"}, DATA_W'(beat_cnt), DATA_W'(acc));
        end
      end
      data_next = dn;
      stop = stop_now;
      @(negedge clk);
      stop = 1'b0;
      it++;
      if (dn) r++;
      if (stop_now || (total != 0 && acc == nbeats)) begin
        chk({tag, "_done"}, DATA_W'(done), DATA_W'(1));
        chk({tag, "_busy_end"}, DATA_W'(busy), DATA_W'(0));
        chk({tag, "_valid_end"}, DATA_W'(io_enable), DATA_W'(0));
        chk({tag, "_cnt_end"}, DATA_W'(beat_cnt), DATA_W'(nbeats));
        ended = 1;
      end else if (it > 2000) begin
        chk({tag, "_timeout"}, DATA_W'(1), DATA_W'(0));
        ended = 1;
      end
    end
    data_next = 1'b1;
    chk({tag, "_queue_left"}, DATA_W'(q.size()), DATA_W'(0));
    q.delete();
    @(negedge clk);
    chk({tag, "_done_pulse"}, DATA_W'(done), DATA_W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_en = 1'b1; start = 1'b0; stop = 1'b0; data_next = 1'b0;
    mode = 2'd0; gap_cfg = '0; seed = '0; beat_total = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", DATA_W'(io_enable), DATA_W'(0));
    chk("rst_data", io_data, '0);
    chk("rst_busy", DATA_W'(busy), DATA_W'(0));
    chk("rst_done", DATA_W'(done), DATA_W'(0));
    chk("rst_cnt", DATA_W'(beat_cnt), DATA_W'(0));
    rst_en = 1'b0;
    @(negedge clk);

    run_stream("b2b",    2'd0, 5'd0,  16'h0001, 32'd4, 4,  -1, -1, 0, -1, 0);
    run_stream("ramp",   2'd1, 5'd0,  16'h0001, 32'd5, 5,  -1, -1, 0, -1, 0);
    run_stream("bp",     2'd0, 5'd2,  16'h0001, 32'd3, 3,  -1, 3,  3, 7,  3);
    run_stream("lfsr1",  2'd2, 5'd0,  16'h0001, 32'd10, 10, -1, -1, 0, -1, 0);
    run_stream("lfsr0",  2'd2, 5'd0,  16'h0000, 32'd3, 3,  -1, -1, 0, -1, 0);
    run_stream("lfsrx",  2'd2, 5'd3,  16'hACE1, 32'd5, 5,  -1, 2,  2, -1, 0);
    run_stream("rsvd",   2'd3, 5'd1,  16'h0001, 32'd3, 3,  -1, -1, 0, -1, 0);
    run_stream("wrap",   2'd1, 5'd30, 16'h0001, 32'd0, 4,  4, -1, 0, -1, 0);

    // Stop while a beat is offered but not accepted: the beat still goes out, then the run ends.
    @(negedge clk);
    mode = 2'd0; gap_cfg = 5'd0; beat_total = 32'd10; start = 1'b1; data_next = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("se_valid", DATA_W'(io_enable), DATA_W'(1));
    chk("se_data", io_data, pat_m(32'd1));
    data_next = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("se_valid_kept", DATA_W'(io_enable), DATA_W'(1));
    chk("se_busy_kept", DATA_W'(busy), DATA_W'(1));
    chk("se_no_done", DATA_W'(done), DATA_W'(0));
    @(negedge clk);
    chk("se_valid_held", DATA_W'(io_enable), DATA_W'(1));
    data_next = 1'b1;
    @(negedge clk);
    chk("se_done", DATA_W'(done), DATA_W'(1));
    chk("se_busy_end", DATA_W'(busy), DATA_W'(0));
    chk("se_valid_end", DATA_W'(io_enable), DATA_W'(0));
    chk("se_cnt", DATA_W'(beat_cnt), DATA_W'(1));
    @(negedge clk);
    chk("se_done_pulse", DATA_W'(done), DATA_W'(0));

    // Start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", DATA_W'(busy), DATA_W'(0));
    repeat (2) @(negedge clk);
    chk("ss_valid", DATA_W'(io_enable), DATA_W'(0));
    chk("ss_done", DATA_W'(done), DATA_W'(0));

    // Asynchronous reset in the middle of a long gap.
    mode = 2'd0; gap_cfg = 5'd20; beat_total = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("ar_busy_before", DATA_W'(busy), DATA_W'(1));
    #1 rst_en = 1'b1;
    #1;
    chk("ar_busy", DATA_W'(busy), DATA_W'(0));
    chk("ar_valid", DATA_W'(io_enable), DATA_W'(0));
    chk("ar_data", io_data, '0);
    chk("ar_cnt", DATA_W'(beat_cnt), DATA_W'(0));
    chk("ar_done", DATA_W'(done), DATA_W'(0));
    @(negedge clk);
    rst_en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("ar_no_done", DATA_W'(done), DATA_W'(0));
      chk("ar_idle", DATA_W'(busy), DATA_W'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
